pc_gen: RTL and testbench

- Fetch-address generator sitting directly upstream of the BTB and the instruction-fetch stage.
- Holds the architectural fetch PC and drives it to the BTB lookup port each cycle.
- Selects the next PC from backend redirect, BTB prediction or sequential PC+4.
- Presents {pc, prediction} to IF with a valid/ready handshake so EX can later check the prediction.

---
 rtl/pc_gen_pkg.sv | 30 +++
 rtl/pc_gen.sv | 124 ++++++++++++
 tb/tb_pc_gen.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared branch-prediction-unit types for the fetch-address
// generator.
//   - pc_gen_state_e : fetch FSM states (BOOT, HALT, RUN)
//   - fetch_req_t    : request handed to IF {pc, pred_taken, pred_target}
//   - PC_GEN_RESET_PC: default fetch address after reset
// Address width comes from `ADDR_WIDTH (defaults to 32 when not defined).

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package pc_gen_pkg;

    localparam int unsigned FETCH_ADDR_W = `ADDR_WIDTH;

    localparam logic [FETCH_ADDR_W-1:0] PC_GEN_RESET_PC = 32'h1c00_0000;

    typedef enum logic [1:0] {
        BOOT,
        HALT,
        RUN
    } pc_gen_state_e;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic                    pred_taken;
        logic [FETCH_ADDR_W-1:0] pred_target;
    } fetch_req_t;

endpackage

// File: rtl/pc_gen.sv
// pc_gen: fetch-address generator between the backend, the BTB and IF.
// Holds the fetch PC, presents it to the BTB every cycle, and chooses the
// next PC from backend redirect, BTB prediction or sequential PC+4.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   btb_lookup_addr      BTB lookup address (always the current PC)
//   btb_pred_addr        BTB predicted target (combinational from lookup)
//   btb_branch           BTB hit / predicted taken
//   redirect_valid/_pc   backend redirect; low two bits of target ignored
//   halt_req             stop fetching until the next redirect
//   out_valid/out_ready  fetch request handshake to IF
//   out_pc               fetch PC
//   out_pred_taken       prediction carried with out_pc
//   out_pred_target      predicted target (out_pc+4 when not taken)
//
// Optional: define PCGEN_PERF_EN to add perf_fetch_cnt, perf_pred_taken_cnt
// and perf_redirect_cnt (clear on rst, wrap silently).

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned               ADDR_W   = `ADDR_WIDTH,
    parameter logic [ADDR_W-1:0]         RESET_PC = PC_GEN_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] btb_lookup_addr,
    input  logic [ADDR_W-1:0] btb_pred_addr,
    input  logic              btb_branch,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_req,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic              out_pred_taken,
    output logic [ADDR_W-1:0] out_pred_target
`ifdef PCGEN_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_pred_taken_cnt,
    output logic [31:0]       perf_redirect_cnt
`endif
);

    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
    localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(4);

    pc_gen_state_e     state_q, state_d;
    logic [ADDR_W-1:0] pc_r, pc_d;
    logic [ADDR_W-1:0] pc_seq;
    logic [ADDR_W-1:0] pred_tgt;
    logic              fire;
    fetch_req_t        req;

    assign pc_seq   = pc_r + PC_STEP;
    assign pred_tgt = btb_pred_addr & WORD_MASK;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_r    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_r    <= pc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_r;
        out_valid = (state_q == RUN);
        fire      = out_valid & out_ready;

        if (redirect_valid) begin
            // Redirect beats halt and any concurrent fire; a fired request
            // is still consumed by IF and squashed by the backend.
            pc_d    = redirect_pc & WORD_MASK;
            state_d = RUN;
        end else if (state_q == BOOT) begin
            state_d = RUN;
        end else if (halt_req) begin
            state_d = HALT;
        end else if (fire) begin
            pc_d = btb_branch ? pred_tgt : pc_seq;
        end
    end

    // Prediction follows the BTB for the current PC, so it stays stable
    // during a stall unless the BTB itself is updated at this index.
    always_comb begin
        req.pc          = pc_r;
        req.pred_taken  = btb_branch;
        req.pred_target = btb_branch ? pred_tgt : pc_seq;
    end

    assign btb_lookup_addr = pc_r;
    assign out_pc          = req.pc;
    assign out_pred_taken  = req.pred_taken;
    assign out_pred_target = req.pred_target;

`ifdef PCGEN_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt      <= '0;
            perf_pred_taken_cnt <= '0;
            perf_redirect_cnt   <= '0;
        end else begin
            if (fire)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (fire && btb_branch)
                perf_pred_taken_cnt <= perf_pred_taken_cnt + 32'd1;
            if (redirect_valid)
                perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: self-checking bench for pc_gen. The bench plays the BTB
// (table or hashed), drives directed and random backend/IF traffic and
// compares every cycle against a behavioural fetch model.
// Define PCGEN_PERF_EN to also check the performance counters.

module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] btb_lookup_addr;
    logic [31:0] btb_pred_addr;
    logic        btb_branch;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt_req = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc;
    logic        out_pred_taken;
    logic [31:0] out_pred_target;
`ifdef PCGEN_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_pred_taken_cnt;
    logic [31:0] perf_redirect_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pc_gen #(.RESET_PC(32'h1c00_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .btb_lookup_addr (btb_lookup_addr),
        .btb_pred_addr   (btb_pred_addr),
        .btb_branch      (btb_branch),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .halt_req        (halt_req),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_pred_taken  (out_pred_taken),
        .out_pred_target (out_pred_target)
`ifdef PCGEN_PERF_EN
        ,
        .perf_fetch_cnt      (perf_fetch_cnt),
        .perf_pred_taken_cnt (perf_pred_taken_cnt),
        .perf_redirect_cnt   (perf_redirect_cnt)
`endif
    );

    // BTB behaviour: mode 0 = table of two entries, mode 1 = hashed.
    int          btb_mode = 0;
    logic [31:0] ent_a_pc = 32'h1c00_0008, ent_a_tgt = 32'h1c00_0100;
    logic [31:0] ent_b_pc = 32'h1c00_0100, ent_b_tgt = 32'h1c00_0300;

    function automatic logic btb_hit(input logic [31:0] a);
        if (btb_mode == 0) return (a == ent_a_pc) || (a == ent_b_pc);
        return (a[5:2] == 4'd6);
    endfunction

    function automatic logic [31:0] btb_tgt(input logic [31:0] a);
        if (btb_mode == 0) return (a == ent_a_pc) ? ent_a_tgt : ent_b_tgt;
        return {a[31:8] + 24'd3, a[7:0] ^ 8'h5b};
    endfunction

    always_comb begin
        btb_branch    = btb_hit(btb_lookup_addr);
        btb_pred_addr = btb_tgt(btb_lookup_addr);
    end

    // Behavioural model: phase 0 boot, 1 fetching, 2 halted.
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_fires, m_hits, m_redirs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: compare outputs at negedge, advance the model on the
    // sampled inputs, return #1 after the next rising edge.
    task automatic cycle();
        logic        hit, fired;
        logic [31:0] tgt;
        @(negedge clk);
        hit = btb_hit(m_pc);
        tgt = btb_tgt(m_pc) & 32'hffff_fffc;
        chk("lookup", btb_lookup_addr, m_pc);
        chk("valid", {31'd0, out_valid}, {31'd0, m_phase == 1});
        chk("pc", out_pc, m_pc);
        chk("taken", {31'd0, out_pred_taken}, {31'd0, hit});
        chk("target", out_pred_target, hit ? tgt : m_pc + 32'd4);
`ifdef PCGEN_PERF_EN
        chk("perf_fetch", perf_fetch_cnt, m_fires);
        chk("perf_taken", perf_pred_taken_cnt, m_hits);
        chk("perf_redir", perf_redirect_cnt, m_redirs);
`endif
        fired = (m_phase == 1) && out_ready;
        if (rst) begin
            m_phase = 0; m_pc = 32'h1c00_0000;
            m_fires = 0; m_hits = 0; m_redirs = 0;
        end else begin
            if (fired) m_fires++;
            if (fired && hit) m_hits++;
            if (redirect_valid) m_redirs++;
            if (redirect_valid) begin
                m_pc = redirect_pc & 32'hffff_fffc; m_phase = 1;
            end else if (m_phase == 0) m_phase = 1;
            else if (halt_req) m_phase = 2;
            else if (fired) m_pc = hit ? tgt : m_pc + 32'd4;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_phase = 0; m_pc = 32'h1c00_0000;
        m_fires = 0; m_hits = 0; m_redirs = 0;
        @(posedge clk);
        #1;
        cycle();                          // reset held
        rst = 1'b0;
        chk("tp_boot_valid", {31'd0, out_valid}, 32'd0);
        cycle();
        chk("tp_pc0", out_pc, 32'h1c00_0000);
        chk("tp_valid0", {31'd0, out_valid}, 32'd1);
        cycle();
        chk("tp_pc1", out_pc, 32'h1c00_0004);

        out_ready = 1'b0;                 // stall three cycles
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("tp_stall_pc", out_pc, 32'h1c00_0004);
            chk("tp_stall_tgt", out_pred_target, 32'h1c00_0008);
            chk("tp_stall_tk", {31'd0, out_pred_taken}, 32'd0);
        end
        out_ready = 1'b1;
        cycle();
        chk("tp_pc2", out_pc, 32'h1c00_0008);
        chk("tp_hit_tk", {31'd0, out_pred_taken}, 32'd1);
        chk("tp_hit_tgt", out_pred_target, 32'h1c00_0100);
        cycle();
        chk("tp_pc_pred", out_pc, 32'h1c00_0100);
        chk("tp_hit2_tk", {31'd0, out_pred_taken}, 32'd1);

        redirect_valid = 1'b1; redirect_pc = 32'h1c00_0203;
        cycle();
        redirect_valid = 1'b0;
        chk("tp_redir_pc", out_pc, 32'h1c00_0200);
        chk("tp_redir_valid", {31'd0, out_valid}, 32'd1);

        redirect_valid = 1'b1; redirect_pc = 32'h1c00_0010;
        cycle();
        redirect_valid = 1'b0;
        halt_req = 1'b1;
        cycle();
        halt_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("tp_halt_valid", {31'd0, out_valid}, 32'd0);
            chk("tp_halt_pc", out_pc, 32'h1c00_0010);
            cycle();
        end
        redirect_valid = 1'b1; redirect_pc = 32'h1c00_0800;
        cycle();
        chk("tp_unhalt_valid", {31'd0, out_valid}, 32'd1);
        chk("tp_unhalt_pc", out_pc, 32'h1c00_0800);

        halt_req = 1'b1; redirect_pc = 32'h1c00_0902;
        cycle();
        halt_req = 1'b0;
        chk("tp_halt_redir", out_pc, 32'h1c00_0900);
        chk("tp_halt_redir_v", {31'd0, out_valid}, 32'd1);

        redirect_pc = 32'hffff_fffd;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        chk("tp_wrap", out_pc, 32'h0000_0000);

        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("tp_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("tp_rst_pc", out_pc, 32'h1c00_0000);

`ifdef PCGEN_PERF_EN
        cycle();                          // BOOT -> RUN, no fire
        for (int i = 0; i < 5; i++) cycle();  // 000,004,008*,100*,300
        out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h1c00_0040;
        cycle();
        out_ready = 1'b1; redirect_valid = 1'b0;
        chk("tp_perf_fetch", perf_fetch_cnt, 32'd5);
        chk("tp_perf_taken", perf_pred_taken_cnt, 32'd2);
        chk("tp_perf_redir", perf_redirect_cnt, 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("tp_perf_clr_f", perf_fetch_cnt, 32'd0);
        chk("tp_perf_clr_t", perf_pred_taken_cnt, 32'd0);
        chk("tp_perf_clr_r", perf_redirect_cnt, 32'd0);
`endif

        btb_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            rst            = ($urandom_range(0, 99) == 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = $urandom;
            halt_req       = ($urandom_range(0, 15) == 0);
            out_ready      = ($urandom_range(0, 9) < 7);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
